attn_seq_ctrl: RTL and testbench
================================

ATTN_SEQ_CTRL -- requirements
Module: attn_seq_ctrl

Interface
REQ-001 SHALL have parameter col, default 8: K rows loaded into the MAC array (1..16).
REQ-002 SHALL have parameter qlen, default 16: Q rows executed, drained and normalized (1..16).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin one attention pass; sampled only in IDLE.
REQ-006 SHALL have port data_valid  input  1  external mem_in word valid this cycle.
REQ-007 SHALL have port fifo_valid  input  1  output FIFO holds a complete row.
REQ-008 SHALL have port inst  output  17  core instruction: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] kernel load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-009 SHALL have port acc, div, fifo_ext_rd  output  1 each  SFP controls; fifo_ext_rd held 0.
REQ-010 SHALL have port in_ready  output  1  high in QWR/KWR: data_valid is consumed.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse in DONE.

Function
REQ-013 SHALL implement states IDLE, QWR, KWR, KLD, EXE, DRN, ACC, DIV, DONE, in that order; DONE -> IDLE.
REQ-014 SHALL leave IDLE for QWR on the edge sampling start=1; start outside IDLE ignored.
REQ-015 QWR: each cycle with data_valid=1 SHALL assert qmem_wr, qkmem_add=row counter, increment; after qlen writes -> KWR; data_valid=0 stalls, no strobe.
REQ-016 KWR: same as QWR using kmem_wr, col writes, then -> KLD.
REQ-017 KLD SHALL last col+1 cycles: kmem_rd with addr 0..col-1 in cycles 0..col-1; inst[6]=1 in cycles 1..col (1-cycle SRAM read latency).
REQ-018 EXE SHALL last qlen+1 cycles: qmem_rd addr 0..qlen-1 in cycles 0..qlen-1; inst[7]=1 in cycles 1..qlen.
REQ-019 DRN: each cycle with fifo_valid=1 SHALL assert ofifo_rd and pmem_wr together, pmem_add=row counter, increment; fifo_valid=0 stalls; after qlen rows -> ACC.
REQ-020 ACC SHALL take 2 cycles per row i (0..qlen-1): pmem_rd addr i, then acc=1.
REQ-021 DIV SHALL take 3 cycles per row i: pmem_rd addr i; div=1; pmem_wr addr i.
REQ-022 All strobes not named for the current state/cycle SHALL be 0; address fields 0 when unused.
REQ-023 All outputs SHALL be registered; counters 4-bit, cleared on every state entry; no wrap beyond qlen-1/col-1.
REQ-024 Never SHALL pmem_rd and pmem_wr, or qmem_rd and qmem_wr, or kmem_rd and kmem_wr, be high together.

Reset
REQ-025 reset=1 at any edge, including mid-pass, SHALL force IDLE, clear counters, drive inst=0, acc=div=fifo_ext_rd=in_ready=busy=done=0 next cycle.
REQ-026 reset SHALL take priority over start, abort and all handshakes.

Configuration
REQ-027 With ATTN_SEQ_ABORT_EN defined SHALL add input abort (1 bit): abort=1 in any non-IDLE state forces IDLE next edge, all outputs 0, done not pulsed; abort wins over simultaneous start.
REQ-028 Without ATTN_SEQ_ABORT_EN the abort port and logic SHALL be absent; a pass runs only to DONE or reset.

Verification
REQ-029 col=8, qlen=16, data_valid=fifo_valid=1, start pulse -> done pulses exactly 147 cycles after the edge sampling start; busy high throughout.
REQ-030 data_valid toggled 1,0 during QWR -> qmem_wr only on valid cycles, addresses 0..15 contiguous, QWR lasts 32 cycles.
REQ-031 KLD window -> kmem_rd addr 0..7 in cycles 0..7, inst[6] high cycles 1..8, never with inst[7].
REQ-032 fifo_valid low 5 cycles mid-DRN -> no ofifo_rd/pmem_wr during gap, pmem_add resumes at next row, 16 writes total.
REQ-033 reset asserted in EXE row 5 -> next cycle inst=0, busy=0; new start runs full pass from QWR addr 0.
REQ-034 ATTN_SEQ_ABORT_EN defined, abort with start in DIV -> IDLE next edge, done never asserted, outputs 0.

Source files
------------

// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: sequencer for one attention pass over the Q/K SRAMs, MAC array and SFP.
// The pass runs Q load, K load, kernel load, execute, drain, accumulate, divide, done.
// Outputs are registered one cycle after the state/cycle they describe.
// Optional feature: define ATTN_SEQ_ABORT_EN to add the 'abort' input, which returns the
// sequencer to idle from any busy state without a done pulse.
module attn_seq_ctrl #(
  parameter int unsigned col  = 8,
  parameter int unsigned qlen = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data_valid,
  input  logic        fifo_valid,
`ifdef ATTN_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic [16:0] inst,
  output logic        acc,
  output logic        div,
  output logic        fifo_ext_rd,
  output logic        in_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    StIdle, StQwr, StKwr, StKld, StExe, StDrn, StAcc, StDiv, StDone
  } state_e;

  localparam logic [3:0] QLast   = 4'(qlen - 1);
  localparam logic [3:0] ColLast = 4'(col - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // Sub-cycle phase: tail cycle in KLD/EXE, 2/3-cycle row steps in ACC/DIV.
  logic [1:0]  ph_q, ph_d;
  logic [16:0] inst_d;
  logic        acc_d, div_d, done_d, busy_d, in_ready_d;
  logic        abort_req;

`ifdef ATTN_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The external FIFO read strobe is never used by this sequencer.
  assign fifo_ext_rd = 1'b0;

  // Next-state, counter and next-output decode from the current state and cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    inst_d  = '0;
    acc_d   = 1'b0;
    div_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        ph_d  = '0;
        if (start) state_d = StQwr;
      end
      StQwr: begin
        if (data_valid) begin
          inst_d[4]     = 1'b1;
          inst_d[15:12] = cnt_q;
          if (cnt_q == QLast) begin
            state_d = StKwr;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end
      end
      StKwr: begin
        if (data_valid) begin
          inst_d[2]     = 1'b1;
          inst_d[15:12] = cnt_q;
          if (cnt_q == ColLast) begin
            state_d = StKld;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end
      end
      StKld: begin
        // Kernel load trails the kmem read by one cycle (SRAM read latency).
        if (ph_q == 2'd0) begin
          inst_d[3]     = 1'b1;
          inst_d[15:12] = cnt_q;
          inst_d[6]     = (cnt_q != 4'd0);
          if (cnt_q == ColLast) ph_d = 2'd1;
          else cnt_d = cnt_q + 4'd1;
        end else begin
          inst_d[6] = 1'b1;
          state_d   = StExe;
          cnt_d     = '0;
          ph_d      = '0;
        end
      end
      StExe: begin
        if (ph_q == 2'd0) begin
          inst_d[5]     = 1'b1;
          inst_d[15:12] = cnt_q;
          inst_d[7]     = (cnt_q != 4'd0);
          if (cnt_q == QLast) ph_d = 2'd1;
          else cnt_d = cnt_q + 4'd1;
        end else begin
          inst_d[7] = 1'b1;
          state_d   = StDrn;
          cnt_d     = '0;
          ph_d      = '0;
        end
      end
      StDrn: begin
        if (fifo_valid) begin
          inst_d[16]   = 1'b1;
          inst_d[0]    = 1'b1;
          inst_d[11:8] = cnt_q;
          if (cnt_q == QLast) begin
            state_d = StAcc;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end
      end
      StAcc: begin
        if (ph_q == 2'd0) begin
          inst_d[1]    = 1'b1;
          inst_d[11:8] = cnt_q;
          ph_d         = 2'd1;
        end else begin
          acc_d = 1'b1;
          ph_d  = 2'd0;
          if (cnt_q == QLast) begin
            state_d = StDiv;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end
      end
      StDiv: begin
        if (ph_q == 2'd0) begin
          inst_d[1]    = 1'b1;
          inst_d[11:8] = cnt_q;
          ph_d         = 2'd1;
        end else if (ph_q == 2'd1) begin
          div_d = 1'b1;
          ph_d  = 2'd2;
        end else begin
          inst_d[0]    = 1'b1;
          inst_d[11:8] = cnt_q;
          ph_d         = 2'd0;
          if (cnt_q == QLast) begin
            state_d = StDone;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
        cnt_d   = '0;
        ph_d    = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        ph_d    = '0;
      end
    endcase
    busy_d = (state_q != StIdle);
    if (abort_req && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
      ph_d    = '0;
      inst_d  = '0;
      acc_d   = 1'b0;
      div_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
    end
    // Aligned with the state register so upstream sees ready in the consuming cycle.
    in_ready_d = (state_d == StQwr) || (state_d == StKwr);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst     <= '0;
      acc      <= 1'b0;
      div      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      inst     <= inst_d;
      acc      <= acc_d;
      div      <= div_d;
      done     <= done_d;
      busy     <= busy_d;
      in_ready <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb_attn_seq_ctrl: self-checking bench for attn_seq_ctrl (col=8, qlen=16).
// The reference model flattens one pass into a queue of steps, each either unconditional
// or gated by data_valid / fifo_valid, and pops one step per cycle when its gate allows.
module tb_attn_seq_ctrl;
  localparam int COL  = 8;
  localparam int QLEN = 16;
  localparam int EXE_START = QLEN + COL + COL + 1;
  localparam int DRN_START = EXE_START + QLEN + 1;
  localparam int DIV_START = DRN_START + QLEN + 2 * QLEN;

  localparam int I_PWR = 1 << 0;
  localparam int I_PRD = 1 << 1;
  localparam int I_KWR = 1 << 2;
  localparam int I_KRD = 1 << 3;
  localparam int I_QWR = 1 << 4;
  localparam int I_QRD = 1 << 5;
  localparam int I_KLD = 1 << 6;
  localparam int I_EXE = 1 << 7;
  localparam int I_OFI = 1 << 16;
  localparam int O_ACC = 1 << 17;
  localparam int O_DIV = 1 << 18;
  localparam int O_DON = 1 << 19;

  logic        clk = 1'b0;
  logic        reset, start, data_valid, fifo_valid;
`ifdef ATTN_SEQ_ABORT_EN
  logic        abort;
`endif
  logic [16:0] inst;
  logic        acc, div, fifo_ext_rd, in_ready, busy, done;

  always #5 clk = ~clk;

  attn_seq_ctrl #(.col(COL), .qlen(QLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_valid (data_valid),
    .fifo_valid (fifo_valid),
`ifdef ATTN_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .inst       (inst),
    .acc        (acc),
    .div        (div),
    .fifo_ext_rd(fifo_ext_rd),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [1:0]  gate;  // 0 always, 1 data_valid, 2 fifo_valid
    logic [19:0] word;  // {done, div, acc, inst}
  } step_t;

  step_t       prog[$];
  int          popped = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [22:0] exp_v, got_v;

  function automatic step_t mk(input logic [1:0] g, input int bits, input int qk, input int pa);
    step_t s;
    s.gate = g;
    s.word = 20'(bits) | (20'(qk) << 12) | (20'(pa) << 8);
    return s;
  endfunction

  task automatic build_prog();
    prog.delete();
    popped = 0;
    for (int i = 0; i < QLEN; i++) prog.push_back(mk(2'd1, I_QWR, i, 0));
    for (int i = 0; i < COL; i++) prog.push_back(mk(2'd1, I_KWR, i, 0));
    for (int c = 0; c <= COL; c++)
      prog.push_back(mk(2'd0, (c < COL ? I_KRD : 0) | (c > 0 ? I_KLD : 0), (c < COL ? c : 0), 0));
    for (int r = 0; r <= QLEN; r++)
      prog.push_back(mk(2'd0, (r < QLEN ? I_QRD : 0) | (r > 0 ? I_EXE : 0), (r < QLEN ? r : 0), 0));
    for (int i = 0; i < QLEN; i++) prog.push_back(mk(2'd2, I_OFI | I_PWR, 0, i));
    for (int i = 0; i < QLEN; i++) begin
      prog.push_back(mk(2'd0, I_PRD, 0, i));
      prog.push_back(mk(2'd0, O_ACC, 0, 0));
    end
    for (int i = 0; i < QLEN; i++) begin
      prog.push_back(mk(2'd0, I_PRD, 0, i));
      prog.push_back(mk(2'd0, O_DIV, 0, 0));
      prog.push_back(mk(2'd0, I_PWR, 0, i));
    end
    prog.push_back(mk(2'd0, O_DON, 0, 0));
  endtask

  // Drive one cycle of inputs, advance the model, then sample the DUT after the edge.
  task automatic run_cycle(input logic dv, input logic fv, input logic st, input logic rst,
                           input logic ab);
    logic [19:0] w;
    logic        b, r;
    data_valid = dv;
    fifo_valid = fv;
    start      = st;
    reset      = rst;
`ifdef ATTN_SEQ_ABORT_EN
    abort      = ab;
`endif
    w = '0;
    b = (prog.size() != 0);
    if (rst) begin
      prog.delete();
      b = 1'b0;
    end else if (prog.size() == 0) begin
      if (st) build_prog();
    end else if (ab) begin
      prog.delete();
      b = 1'b0;
    end else if (prog[0].gate == 2'd0 || (prog[0].gate == 2'd1 && dv) ||
                 (prog[0].gate == 2'd2 && fv)) begin
      w = prog[0].word;
      void'(prog.pop_front());
      popped++;
    end
    r = (prog.size() != 0) && (prog[0].gate == 2'd1);
    exp_v = {w, b, r, 1'b0};
    @(posedge clk);
    #1;
    got_v = {done, div, acc, inst, busy, in_ready, fifo_ext_rd};
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %h want %h", k, got_v, exp_v);
      end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_v !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 0", got_v);
    end
  endtask

  task automatic test_full_pass();
    int done_at = -1;
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 300; k++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL full_pass cyc %0d: got %h want %h", k, got_v, exp_v);
      end
      if (k <= 147) begin
        n_cmp++;
        if (busy !== 1'b1 || (inst[6] && inst[7])) begin
          n_bad++;
          $display("FAIL full_busy cyc %0d: busy=%b k6=%b k7=%b want busy=1 not both", k, busy,
                   inst[6], inst[7]);
        end
      end
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    n_cmp++;
    if (done_at != 147) begin
      n_bad++;
      $display("FAIL full_latency: got %0d want 147", done_at);
    end
  endtask

  task automatic test_qwr_toggle();
    int nxt  = 0;
    int last = 0;
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 500; k++) begin
      run_cycle(k % 2 == 0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL qwr_toggle cyc %0d: got %h want %h", k, got_v, exp_v);
      end
      if (inst[4]) begin
        n_cmp++;
        if (inst[15:12] !== 4'(nxt)) begin
          n_bad++;
          $display("FAIL qwr_addr: got %0d want %0d", inst[15:12], nxt);
        end
        nxt++;
        last = k;
      end
      if (done === 1'b1) break;
    end
    n_cmp++;
    if (nxt != QLEN || last != 32) begin
      n_bad++;
      $display("FAIL qwr_len: got %0d writes over %0d cycles want 16 over 32", nxt, last);
    end
  endtask

  task automatic test_drn_gap();
    int   gap = 0;
    int   nxt = 0;
    bit   gapped = 1'b0;
    logic fv;
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 400; k++) begin
      fv = 1'b1;
      if (!gapped && popped == DRN_START + 8) begin
        gap    = 5;
        gapped = 1'b1;
      end
      if (gap > 0) begin
        fv = 1'b0;
        gap--;
      end
      run_cycle(1'b1, fv, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL drn_gap cyc %0d: got %h want %h", k, got_v, exp_v);
      end
      if (!fv) begin
        n_cmp++;
        if (inst[16] || inst[0]) begin
          n_bad++;
          $display("FAIL drn_stall: got ofifo=%b pwr=%b want 0 0", inst[16], inst[0]);
        end
      end
      if (inst[16]) begin
        n_cmp++;
        if (inst[0] !== 1'b1 || inst[11:8] !== 4'(nxt)) begin
          n_bad++;
          $display("FAIL drn_addr: got pwr=%b addr=%0d want 1 %0d", inst[0], inst[11:8], nxt);
        end
        nxt++;
      end
      if (done === 1'b1) break;
    end
    n_cmp++;
    if (nxt != QLEN || !gapped) begin
      n_bad++;
      $display("FAIL drn_count: got %0d rows want 16", nxt);
    end
  endtask

  task automatic test_reset_mid();
    int done_at = -1;
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 100 && popped != EXE_START + 5; k++)
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (got_v !== exp_v || inst !== 17'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h", got_v, exp_v);
    end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 300; k++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_rerun cyc %0d: got %h want %h", k, got_v, exp_v);
      end
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    n_cmp++;
    if (done_at != 147) begin
      n_bad++;
      $display("FAIL reset_rerun_latency: got %0d want 147", done_at);
    end
  endtask

  task automatic test_random();
    int dones = 0;
    for (int k = 0; k < 700; k++) begin
      run_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h want %h", k, got_v, exp_v);
      end
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones < 2) begin
      n_bad++;
      $display("FAIL random_passes: got %0d done pulses want at least 2", dones);
    end
  endtask

`ifdef ATTN_SEQ_ABORT_EN
  task automatic test_abort();
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 200 && popped != DIV_START + 4; k++)
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (got_v !== exp_v || got_v !== 23'd0) begin
      n_bad++;
      $display("FAIL abort: got %h want 0", got_v);
    end
    for (int k = 0; k < 20; k++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v || done !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_idle cyc %0d: got %h want %h", k, got_v, exp_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_pass();
    test_qwr_toggle();
    test_drn_gap();
    test_reset_mid();
    test_random();
`ifdef ATTN_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
